// File: rtl/mult_ctrl.sv
// Sequencer for a shift-add multiplier: one Load, then WIDTH rounds of "add if M, then shift".
// Drives Load/Ad/Sh into the accumulator and a start/busy/done handshake upstream.
module mult_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic M,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StShift,
    StDone
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) state_q <= StLoad;
        end
        StLoad: begin
          cnt_q   <= '0;
          state_q <= StCheck;
        end
        StCheck: begin
          // M=1 defers the shift (and the count) to StShift after the add.
          if (M) begin
            state_q <= StShift;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            state_q <= (cnt_q == CntLast) ? StDone : StCheck;
          end
        end
        StShift: begin
          cnt_q   <= cnt_q + CW'(1);
          state_q <= (cnt_q == CntLast) ? StDone : StCheck;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    Load = 1'b0;
    Ad   = 1'b0;
    Sh   = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (state_q)
      StIdle:  busy = 1'b0;
      StLoad:  Load = 1'b1;
      StCheck: begin
        Ad = M;
        Sh = ~M;
      end
      StShift: Sh   = 1'b1;
      StDone:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a behavioural 33-bit accumulator/adder closing the M loop.
module tb_mult_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic M;
  logic Load, Ad, Sh, busy, done;

  logic [15:0] a_op = '0;
  logic [15:0] b_op = '0;
  logic [32:0] acc  = '0;

  int checks = 0;
  int errors = 0;

  mult_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .M     (M),
    .Load  (Load),
    .Ad    (Ad),
    .Sh    (Sh),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Accumulator: high part at [32:16] (with carry), multiplier in low half.
  always @(posedge clk) begin
    if (Load)    acc <= {17'b0, b_op};
    else if (Ad) acc[32:16] <= acc[32:16] + {1'b0, a_op};
    else if (Sh) acc <= acc >> 1;
  end
  assign M = acc[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply a one-cycle start so that the next negedge is Load cycle 1.
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Sample each cycle from Load (cycle 1) until done or a 60-cycle budget runs out.
  task automatic observe(input bit pulse, input bit hold,
                         output int done_cyc, output int n_ad, output int n_sh,
                         output int n_load, output bit load_first, output bit busy_ok,
                         output bit adj_ok, output bit excl_ok, output logic [31:0] prod);
    bit prev_ad = 1'b0;
    done_cyc = 0; n_ad = 0; n_sh = 0; n_load = 0;
    load_first = 1'b0; busy_ok = 1'b1; adj_ok = 1'b1; excl_ok = 1'b1; prod = 'x;
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) load_first = Load;
      if (Load) n_load++;
      if (Ad)   n_ad++;
      if (Sh)   n_sh++;
      if (Ad && prev_ad) adj_ok = 1'b0;
      prev_ad = Ad;
      if (int'(Load) + int'(Ad) + int'(Sh) > 1) excl_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done) begin
        done_cyc = cyc;
        prod = acc[31:0];
      end
      // Driven here, sampled at the following edge: lands in cycles 3..10.
      start = pulse && cyc >= 2 && cyc <= 9;
      if (done && hold) start = 1'b1;
    end
  endtask

  int          dc, nad, nsh, nld;
  bit          lf, bok, aok, eok;
  logic [31:0] pr;

  initial begin
    // T1: reset with start held high.
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {27'b0, Load, Ad, Sh, busy, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_after_release", {27'b0, Load, Ad, Sh, busy, done}, 32'h0);

    // T2: B=0, M stays 0.
    a_op = 16'h1234; b_op = 16'h0000;
    kick();
    observe(0, 0, dc, nad, nsh, nld, lf, bok, aok, eok, pr);
    check("t2_load_first", {31'b0, lf}, 32'd1);
    check("t2_done_cycle", dc, 32'd18);
    check("t2_sh_count", nsh, 32'd16);
    check("t2_ad_count", nad, 32'd0);
    check("t2_busy", {31'b0, bok}, 32'd1);
    check("t2_product", pr, 32'h0);
    @(negedge clk);
    check("t2_idle_after", {27'b0, Load, Ad, Sh, busy, done}, 32'h0);

    // T3: B=FFFF, M stays 1; Ad/Sh alternate.
    a_op = 16'h0001; b_op = 16'hFFFF;
    kick();
    observe(0, 0, dc, nad, nsh, nld, lf, bok, aok, eok, pr);
    check("t3_done_cycle", dc, 32'd34);
    check("t3_ad_count", nad, 32'd16);
    check("t3_sh_count", nsh, 32'd16);
    check("t3_no_ad_adj", {31'b0, aok}, 32'd1);
    check("t3_exclusive", {31'b0, eok}, 32'd1);
    check("t3_product", pr, 32'h0000FFFF);

    // T4: products.
    a_op = 16'd3; b_op = 16'd5;
    kick();
    observe(0, 0, dc, nad, nsh, nld, lf, bok, aok, eok, pr);
    check("t4a_done_cycle", dc, 32'd20);
    check("t4a_product", pr, 32'd15);
    a_op = 16'hFFFF; b_op = 16'hFFFF;
    kick();
    observe(0, 0, dc, nad, nsh, nld, lf, bok, aok, eok, pr);
    check("t4b_done_cycle", dc, 32'd34);
    check("t4b_product", pr, 32'hFFFE0001);

    // T5: start pulsed while busy, then held across DONE.
    a_op = 16'd7; b_op = 16'h0009;
    kick();
    observe(1, 0, dc, nad, nsh, nld, lf, bok, aok, eok, pr);
    check("t5_single_load", nld, 32'd1);
    check("t5_done_cycle", dc, 32'd20);
    check("t5_product", pr, 32'd63);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_requeue", {30'b0, Load, done}, 32'h0);
    end
    a_op = 16'd2; b_op = 16'h0000;
    kick();
    observe(0, 1, dc, nad, nsh, nld, lf, bok, aok, eok, pr);
    check("t5_hold_done_cycle", dc, 32'd18);
    @(negedge clk);
    check("t5_hold_idle_gap", {30'b0, Load, busy}, 32'h0);
    @(posedge clk);
    #1 start = 1'b0;
    observe(0, 0, dc, nad, nsh, nld, lf, bok, aok, eok, pr);
    check("t5_hold_reload", {31'b0, lf}, 32'd1);
    check("t5_hold_done2", dc, 32'd18);

    // T6: reset after the 5th shift, no done, then a clean multiply.
    a_op = 16'd9; b_op = 16'h0000;
    kick();
    nsh = 0;
    for (int cyc = 0; cyc < 40 && nsh < 5; cyc++) begin
      @(negedge clk);
      if (Sh) nsh++;
    end
    check("t6_reached_5th_sh", nsh, 32'd5);
    rst = 1'b1;
    #1 check("t6_async_clear", {27'b0, Load, Ad, Sh, busy, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nld = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy || Load) nld++;
    end
    check("t6_no_done_after_rst", nld, 32'd0);
    a_op = 16'd3; b_op = 16'd5;
    kick();
    observe(0, 0, dc, nad, nsh, nld, lf, bok, aok, eok, pr);
    check("t6_done_cycle", dc, 32'd20);
    check("t6_product", pr, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
